// File: rtl/cpu_trace_fifo.sv
// cpu_trace_fifo: commit-trace FIFO with sequence numbering, drop counting and show-ahead valid/ready output
module cpu_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              pc,
  input  logic [31:0]              rs_value,
  input  logic [31:0]              rt_value,
  input  logic [31:0]              rd_value,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_rs_value,
  output logic [31:0]              out_rt_value,
  output logic [31:0]              out_rd_value,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [SEQ_W-1:0]         drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      rs;
    logic [31:0]      rt;
    logic [31:0]      rd;
    logic [SEQ_W-1:0] seq;
  } rec_t;
  rec_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SEQ_W-1:0] seq_ctr;
  logic pop, push_ok, drop;
  assign out_valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign {out_pc, out_rs_value, out_rt_value, out_rd_value, out_seq} = mem[rd_ptr];
  always_comb begin
    pop = out_valid & out_ready;
    push_ok = commit_valid & ~clear & (~full | pop);
    drop = commit_valid & ~clear & full & ~pop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      seq_ctr <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (commit_valid) seq_ctr <= seq_ctr + SEQ_W'(1);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= (push_ok & ~pop) ? count + (AW+1)'(1) : (pop & ~push_ok) ? count - (AW+1)'(1) : count;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + SEQ_W'(1);
      end
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= '{pc: pc, rs: rs_value, rt: rt_value, rd: rd_value, seq: seq_ctr};
  end
endmodule
